// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one downstream memory port.
// Latency: grant in IDLE, request visible next cycle; backpressure by holding mem_* until mem_ready.
module mem_arbiter #(
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ireq_valid,
  input  logic [63:0] ireq_addr,
  output logic        iresp_ready,
  output logic [31:0] iresp_data,
  input  logic        dreq_valid,
  input  logic [63:0] dreq_addr,
  input  logic [2:0]  dreq_size,
  input  logic [7:0]  dreq_strobe,
  input  logic [63:0] dreq_data,
  output logic        dresp_ready,
  output logic [63:0] dresp_data,
  output logic        mem_valid,
  output logic [63:0] mem_addr,
  output logic [2:0]  mem_size,
  output logic [7:0]  mem_strobe,
  output logic [63:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [63:0] mem_rdata
);

  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_t      state, state_nxt;
  logic        owner, owner_nxt;
  logic        last_grant, last_grant_nxt;
  logic [63:0] addr_q, addr_nxt;
  logic [2:0]  size_q, size_nxt;
  logic [7:0]  strobe_q, strobe_nxt;
  logic [63:0] wdata_q, wdata_nxt;
  logic        grant_d;
  logic        busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= OWN_I;
      last_grant <= OWN_I;
      addr_q     <= '0;
      size_q     <= '0;
      strobe_q   <= '0;
      wdata_q    <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_grant <= last_grant_nxt;
      addr_q     <= addr_nxt;
      size_q     <= size_nxt;
      strobe_q   <= strobe_nxt;
      wdata_q    <= wdata_nxt;
    end
  end

  // dbus wins a tie when fixed priority is on, or when ibus had the previous grant
  always_comb begin
    grant_d = dreq_valid && (!ireq_valid || (FIXED_PRIO != 0) || (last_grant == OWN_I));
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_grant_nxt = last_grant;
    addr_nxt       = addr_q;
    size_nxt       = size_q;
    strobe_nxt     = strobe_q;
    wdata_nxt      = wdata_q;
    case (state)
      IDLE: begin
        if (grant_d) begin
          state_nxt      = BUSY;
          owner_nxt      = OWN_D;
          last_grant_nxt = OWN_D;
          addr_nxt       = dreq_addr;
          size_nxt       = dreq_size;
          strobe_nxt     = dreq_strobe;
          wdata_nxt      = dreq_data;
        end else if (ireq_valid) begin
          state_nxt      = BUSY;
          owner_nxt      = OWN_I;
          last_grant_nxt = OWN_I;
          addr_nxt       = ireq_addr;
          size_nxt       = 3'b010;
          strobe_nxt     = 8'h00;
          wdata_nxt      = 64'h0;
        end
      end
      BUSY: begin
        if (mem_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy        = (state == BUSY);
  assign mem_valid   = busy;
  assign mem_addr    = addr_q;
  assign mem_size    = size_q;
  assign mem_strobe  = strobe_q;
  assign mem_wdata   = wdata_q;
  assign iresp_ready = busy && mem_ready && (owner == OWN_I);
  assign dresp_ready = busy && mem_ready && (owner == OWN_D);
  // Read data is forced to zero outside BUSY so nothing leaks while idle or in reset
  assign dresp_data  = busy ? mem_rdata : 64'h0;
  assign iresp_data  = !busy ? 32'h0 : (addr_q[2] ? mem_rdata[63:32] : mem_rdata[31:0]);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: round-robin instance (dut) and fixed-priority instance (dutp) share all inputs.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        mem_ready;
  logic [63:0] mem_rdata;

  logic        iresp_ready, dresp_ready, mem_valid;
  logic [31:0] iresp_data;
  logic [63:0] dresp_data, mem_addr, mem_wdata;
  logic [2:0]  mem_size;
  logic [7:0]  mem_strobe;

  logic        p_iresp_ready, p_dresp_ready, p_mem_valid;
  logic [31:0] p_iresp_data;
  logic [63:0] p_dresp_data, p_mem_addr, p_mem_wdata;
  logic [2:0]  p_mem_size;
  logic [7:0]  p_mem_strobe;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.FIXED_PRIO(0)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_ready(iresp_ready), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_ready(dresp_ready), .dresp_data(dresp_data),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_size(mem_size),
    .mem_strobe(mem_strobe), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.FIXED_PRIO(1)) dutp (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_ready(p_iresp_ready), .iresp_data(p_iresp_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_ready(p_dresp_ready), .dresp_data(p_dresp_data),
    .mem_valid(p_mem_valid), .mem_addr(p_mem_addr), .mem_size(p_mem_size),
    .mem_strobe(p_mem_strobe), .mem_wdata(p_mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  task automatic test_reset();
    reset = 1'b0;
    ireq_valid = 0; ireq_addr = 0;
    dreq_valid = 0; dreq_addr = 0; dreq_size = 0; dreq_strobe = 0; dreq_data = 0;
    mem_ready = 1; mem_rdata = 64'hA5A5_A5A5_5A5A_5A5A;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({mem_valid, iresp_ready, dresp_ready, p_mem_valid, p_iresp_ready, p_dresp_ready} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 000000",
               {mem_valid, iresp_ready, dresp_ready, p_mem_valid, p_iresp_ready, p_dresp_ready});
    end
    checks++;
    if ({mem_addr, mem_size, mem_strobe, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_fields: got addr=%h size=%0d strobe=%h wdata=%h required all 0",
               mem_addr, mem_size, mem_strobe, mem_wdata);
    end
    checks++;
    if ({dresp_data, iresp_data} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data: got d=%h i=%h required 0", dresp_data, iresp_data);
    end
    // mem_ready high while idle must not produce anything
    @(negedge clk); reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      checks++;
      if ({mem_valid, iresp_ready, dresp_ready} !== 3'b000) begin
        errors++;
        $display("FAIL idle_ready_ignored cycle %0d: got %b required 000", c, {mem_valid, iresp_ready, dresp_ready});
      end
    end
    mem_ready = 0;
  endtask

  task automatic test_fetch();
    int pulses;
    pulses = 0;
    @(negedge clk);
    ireq_valid = 1; ireq_addr = 64'h8000_0004; mem_ready = 0; mem_rdata = 64'h0;
    #1;
    checks++;
    if (mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_not_yet: mem_valid got %b required 0", mem_valid);
    end
    @(negedge clk);
    ireq_valid = 0; ireq_addr = 64'hFFFF_0000_FFFF_0000;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      pulses += int'(iresp_ready) + int'(dresp_ready);
      checks++;
      if ({mem_valid, mem_addr, mem_size, mem_strobe, mem_wdata} !==
          {1'b1, 64'h8000_0004, 3'd2, 8'h00, 64'h0}) begin
        errors++;
        $display("FAIL fetch_hold cycle %0d: got v=%b addr=%h size=%0d strobe=%h wdata=%h required v=1 addr=80000004 size=2 strobe=0 wdata=0",
                 c, mem_valid, mem_addr, mem_size, mem_strobe, mem_wdata);
      end
    end
    @(negedge clk);
    mem_ready = 1; mem_rdata = 64'h1111_2222_3333_4444;
    #1;
    checks++;
    if ({iresp_ready, dresp_ready, iresp_data} !== {2'b10, 32'h1111_2222}) begin
      errors++;
      $display("FAIL fetch_resp: got irdy=%b drdy=%b data=%h required 1 0 11112222",
               iresp_ready, dresp_ready, iresp_data);
    end
    pulses += int'(iresp_ready);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      mem_ready = (c == 0) ? 1'b1 : 1'b0;
      #1;
      pulses += int'(iresp_ready) + int'(dresp_ready);
    end
    checks++;
    if (pulses !== 1 || mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_single_pulse: got pulses=%0d mem_valid=%b required 1 and 0", pulses, mem_valid);
    end
  endtask

  task automatic test_store();
    @(negedge clk);
    dreq_valid = 1; dreq_addr = 64'h100; dreq_size = 3'd3; dreq_strobe = 8'hFF;
    dreq_data = 64'hDEAD_BEEF_0000_0001; mem_ready = 0;
    @(negedge clk);
    dreq_valid = 0;
    for (int c = 0; c < 2; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++;
      if ({mem_valid, mem_addr, mem_size, mem_strobe, mem_wdata, dresp_ready, iresp_ready} !==
          {1'b1, 64'h100, 3'd3, 8'hFF, 64'hDEAD_BEEF_0000_0001, 2'b00}) begin
        errors++;
        $display("FAIL store_hold cycle %0d: got v=%b addr=%h size=%0d strobe=%h wdata=%h rdy=%b%b required v=1 addr=100 size=3 strobe=ff wdata=deadbeef00000001 rdy=00",
                 c, mem_valid, mem_addr, mem_size, mem_strobe, mem_wdata, dresp_ready, iresp_ready);
      end
    end
    @(negedge clk);
    mem_ready = 1; #1;
    checks++;
    if ({dresp_ready, iresp_ready, p_dresp_ready} !== 3'b101) begin
      errors++;
      $display("FAIL store_resp: got d=%b i=%b pd=%b required 1 0 1", dresp_ready, iresp_ready, p_dresp_ready);
    end
    @(negedge clk);
    mem_ready = 0; #1;
    checks++;
    if ({mem_valid, dresp_ready} !== 2'b00) begin
      errors++;
      $display("FAIL store_done: got v=%b d=%b required 0 0", mem_valid, dresp_ready);
    end
  endtask

  task automatic test_stability();
    @(negedge clk);
    dreq_valid = 1; dreq_addr = 64'h200; dreq_size = 3'd2; dreq_strobe = 8'h00; dreq_data = 64'h0;
    @(negedge clk);
    dreq_addr = 64'h999; dreq_size = 3'd1; dreq_strobe = 8'h0F; dreq_data = 64'h77;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({mem_addr, mem_size, mem_strobe, mem_wdata} !== {64'h200, 3'd2, 8'h00, 64'h0}) begin
      errors++;
      $display("FAIL stability: got addr=%h size=%0d strobe=%h wdata=%h required 200 2 00 0",
               mem_addr, mem_size, mem_strobe, mem_wdata);
    end
    dreq_valid = 0;
    @(negedge clk);
    mem_ready = 1; mem_rdata = 64'h0123_4567_89AB_CDEF; #1;
    checks++;
    if ({dresp_ready, dresp_data} !== {1'b1, 64'h0123_4567_89AB_CDEF}) begin
      errors++;
      $display("FAIL read_data: got rdy=%b data=%h required 1 0123456789abcdef", dresp_ready, dresp_data);
    end
    @(negedge clk);
    mem_ready = 0;
  endtask

  task automatic test_back_to_back();
    logic exp_d, exp_i, exp_v, exp_pd;
    reset = 0;
    @(negedge clk);
    ireq_valid = 1; ireq_addr = 64'h1000;
    dreq_valid = 1; dreq_addr = 64'h2000; dreq_size = 3'd3; dreq_strobe = 8'h00; dreq_data = 64'h0;
    mem_ready = 1; mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    @(negedge clk);
    reset = 1;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      // round-robin: D at cycle 1, I at 3, D at 5, I at 7; fixed: D on every odd cycle
      exp_v  = (c % 2 == 1);
      exp_d  = (c % 4 == 1);
      exp_i  = (c % 4 == 3);
      exp_pd = (c % 2 == 1);
      checks++;
      if ({mem_valid, dresp_ready, iresp_ready} !== {exp_v, exp_d, exp_i}) begin
        errors++;
        $display("FAIL rr_order cycle %0d: got v=%b d=%b i=%b required v=%b d=%b i=%b",
                 c, mem_valid, dresp_ready, iresp_ready, exp_v, exp_d, exp_i);
      end
      checks++;
      if ({p_dresp_ready, p_iresp_ready} !== {exp_pd, 1'b0}) begin
        errors++;
        $display("FAIL fixed_prio cycle %0d: got d=%b i=%b required d=%b i=0",
                 c, p_dresp_ready, p_iresp_ready, exp_pd);
      end
      if (c == 3) begin
        checks++;
        if ({mem_addr, iresp_data} !== {64'h1000, 32'hCCCC_DDDD}) begin
          errors++;
          $display("FAIL rr_fetch_low_word: got addr=%h data=%h required 1000 ccccdddd", mem_addr, iresp_data);
        end
      end
    end
    @(negedge clk);
    ireq_valid = 0; dreq_valid = 0;
    repeat (2) @(negedge clk);
    mem_ready = 0;
  endtask

  task automatic test_reset_mid_busy();
    @(negedge clk);
    dreq_valid = 1; dreq_addr = 64'h4000; dreq_size = 3'd3; dreq_strobe = 8'h0F; dreq_data = 64'h55;
    mem_ready = 0;
    @(negedge clk);
    dreq_addr = 64'h300; dreq_strobe = 8'h00;
    #1;
    checks++;
    if ({mem_valid, mem_addr} !== {1'b1, 64'h4000}) begin
      errors++;
      $display("FAIL abort_setup: got v=%b addr=%h required 1 4000", mem_valid, mem_addr);
    end
    #1; reset = 0; #1;
    checks++;
    if ({mem_valid, mem_addr, mem_strobe} !== {1'b0, 64'h0, 8'h00}) begin
      errors++;
      $display("FAIL abort_async: got v=%b addr=%h strobe=%h required 0 0 00", mem_valid, mem_addr, mem_strobe);
    end
    mem_ready = 1; #1;
    checks++;
    if ({dresp_ready, iresp_ready} !== 2'b00) begin
      errors++;
      $display("FAIL abort_no_pulse: got d=%b i=%b required 0 0", dresp_ready, iresp_ready);
    end
    @(negedge clk);
    reset = 1; #1;
    checks++;
    if ({mem_valid, dresp_ready} !== 2'b00) begin
      errors++;
      $display("FAIL abort_release_idle: got v=%b d=%b required 0 0", mem_valid, dresp_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({mem_valid, mem_addr, mem_strobe, dresp_ready} !== {1'b1, 64'h300, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL abort_fresh_grant: got v=%b addr=%h strobe=%h d=%b required 1 300 00 1",
               mem_valid, mem_addr, mem_strobe, dresp_ready);
    end
    dreq_valid = 0;
    @(negedge clk);
    mem_ready = 0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_stability();
    test_back_to_back();
    test_reset_mid_busy();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter FIXED_PRIO, default 0: 0 = round-robin between requesters; 1 = dbus always wins ties.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port ireq_valid  in  1  instruction fetch request.
REQ-005 SHALL have port ireq_addr  in  64  fetch byte address.
REQ-006 SHALL have port iresp_ready  out  1  one-cycle fetch completion pulse.
REQ-007 SHALL have port iresp_data  out  32  fetched instruction.
REQ-008 SHALL have port dreq_valid  in  1  data request.
REQ-009 SHALL have port dreq_addr  in  64  data byte address.
REQ-010 SHALL have port dreq_size  in  3  log2 access bytes.
REQ-011 SHALL have port dreq_strobe  in  8  byte write enables; all-zero means read.
REQ-012 SHALL have port dreq_data  in  64  write data.
REQ-013 SHALL have port dresp_ready  out  1  one-cycle data completion pulse.
REQ-014 SHALL have port dresp_data  out  64  read data.
REQ-015 SHALL have ports mem_valid out 1, mem_addr out 64, mem_size out 3, mem_strobe out 8, mem_wdata out 64: shared downstream request.
REQ-016 SHALL have ports mem_ready in 1, mem_rdata in 64: downstream completion and read data.

Function
REQ-017 SHALL implement states IDLE and BUSY; plus owner register (I/D) and last_grant register (I/D).
REQ-018 In IDLE, no request valid: remain IDLE; mem_valid=0.
REQ-019 In IDLE, exactly one valid: grant it, latch its fields, enter BUSY next cycle.
REQ-020 In IDLE, both valid, FIXED_PRIO=0: grant the requester that is not last_grant; FIXED_PRIO=1: grant dbus.
REQ-021 On grant, last_grant SHALL become the granted requester.
REQ-022 Fetch grant SHALL latch mem_addr=ireq_addr, mem_size=3'b010, mem_strobe=0, mem_wdata=0.
REQ-023 Data grant SHALL latch dreq_addr, dreq_size, dreq_strobe, dreq_data unchanged.
REQ-024 In BUSY, mem_valid=1 with latched fields, held stable until mem_ready; requester input changes ignored.
REQ-025 In BUSY with mem_ready=1: same cycle, owner's resp_ready=1 (other requester's resp_ready=0); next state IDLE.
REQ-026 dresp_data SHALL equal mem_rdata; iresp_data SHALL equal mem_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0].
REQ-027 resp_ready SHALL never assert outside BUSY&&mem_ready; both never assert together.
REQ-028 Minimum latency: request in IDLE at cycle N -> mem_valid at N+1 -> resp_ready at N+1 if mem_ready already high.
REQ-029 Requester still valid in the cycle after its resp_ready is a new request and SHALL be arbitrated normally.
REQ-030 mem_ready while IDLE SHALL be ignored.
REQ-031 Under round-robin with both requesters continuously valid, grants SHALL strictly alternate D,I,D,I...

Reset
REQ-032 reset low SHALL asynchronously force IDLE, owner=I, last_grant=I, all latched fields 0.
REQ-033 During reset, mem_valid, iresp_ready, dresp_ready SHALL be 0; data outputs 0.
REQ-034 Reset asserted mid-BUSY SHALL abandon the transaction with no response pulse; after release, arbitration restarts from IDLE.

Verification
REQ-035 Fetch only: ireq_valid=1, addr=0x8000_0004, mem_ready after 3 cycles, rdata=0x1111_2222_3333_4444 -> mem_size=2, strobe=0, iresp_data=0x1111_2222, single iresp_ready pulse.
REQ-036 Store: dreq addr=0x100, size=3, strobe=0xFF, data=0xDEAD_BEEF_0000_0001 -> identical values on mem_* until mem_ready; one dresp_ready pulse.
REQ-037 Contention, FIXED_PRIO=0, both valid from reset, mem_ready=1 always -> grant order D,I,D,I over 4 transactions, one pulse per BUSY cycle.
REQ-038 FIXED_PRIO=1, both continuously valid -> every grant to dbus; iresp_ready never asserts.
REQ-039 Stability: change dreq_addr during BUSY -> mem_addr keeps latched value until mem_ready.
REQ-040 Reset pulse during BUSY before mem_ready -> mem_valid drops immediately, no resp pulse, fresh grant after release.
